// File: rtl/coin_start_front.sv
// coin_start_front: synchronizes and debounces coin/start inputs, keeps a saturating credit count,
// and drives fsm_ctrl's coin/start with a hold-until-acknowledged handshake. Optional macro: SESSION_TIMEOUT_EN.
`default_nettype none

module coin_start_front #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CREDIT_W        = 3,
  parameter int MAX_CREDIT      = 7,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_raw,
  input  logic                start_raw,
  input  logic                lock,
  input  logic                unlock,
  output logic                coin,
  output logic                start,
  output logic [CREDIT_W-1:0] credit,
  output logic                credit_full,
  output logic                overflow,
  output logic                timeout
);

  localparam int                  DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CREDIT_W-1:0] MAXC = CREDIT_W'(MAX_CREDIT);

  typedef enum logic [1:0] {IDLE, COIN_REQ, SESSION, START_REQ} state_t;

  // Bit 0 is the coin channel, bit 1 the start channel.
  logic [1:0]    sync1_q, sync2_q, deb_q, ev_q;
  logic [DW-1:0] cnt_q [2];

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                overflow_q, overflow_d;
  logic                coin_q, start_q;
  logic                timeout_q, timeout_d;
  logic                dec, expire;
  logic                coin_ev, start_ev;

  assign coin_ev  = ev_q[0];
  assign start_ev = ev_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      ev_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= {start_raw, coin_raw};
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          // The edge on which the counter would reach the threshold is the flip edge.
          cnt_q[i] <= '0;
          deb_q[i] <= sync2_q[i];
          ev_q[i]  <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef SESSION_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != SESSION) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign expire = (state_q == SESSION) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = 1'b0;
    dec       = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (credit_q != '0 && lock) begin
          state_d = COIN_REQ;
          dec     = 1'b1;
        end
      end
      COIN_REQ: begin
        if (unlock) begin
          state_d = SESSION;
          pend_d  = start_ev;
        end
      end
      SESSION: begin
        // A real start press wins over a simultaneous timeout expiry.
        if (start_ev || pend_q) begin
          state_d = START_REQ;
        end else if (expire) begin
          state_d   = START_REQ;
          timeout_d = 1'b1;
        end
      end
      START_REQ: begin
        if (lock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d   = credit_q;
    overflow_d = 1'b0;
    if (coin_ev && !dec) begin
      if (credit_q == MAXC) begin
        overflow_d = 1'b1;
      end else begin
        credit_d = credit_q + 1'b1;
      end
    end else if (dec && !coin_ev) begin
      credit_d = credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      credit_q   <= '0;
      overflow_q <= 1'b0;
      coin_q     <= 1'b0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      coin_q     <= (state_d == COIN_REQ);
      start_q    <= (state_d == START_REQ);
      timeout_q  <= timeout_d;
    end
  end

  assign coin        = coin_q;
  assign start       = start_q;
  assign credit      = credit_q;
  assign credit_full = (credit_q == MAXC);
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_coin_start_front.sv
// Directed testbench for coin_start_front: debounce latency, handshakes, credit saturation, reset, timeout.
`default_nettype none

module tb_coin_start_front;

  logic       clk = 1'b0;
  logic       rst, coin_raw, start_raw, lock, unlock;
  logic       coin, start, credit_full, overflow, timeout;
  logic [2:0] credit;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  coin_start_front #(
    .DEBOUNCE_CYCLES(4),
    .CREDIT_W       (3),
    .MAX_CREDIT     (7),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_raw   (coin_raw),
    .start_raw  (start_raw),
    .lock       (lock),
    .unlock     (unlock),
    .coin       (coin),
    .start      (start),
    .credit     (credit),
    .credit_full(credit_full),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; coin_raw = 1'b0; start_raw = 1'b0; lock = 1'b0; unlock = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({coin, start, credit, credit_full, overflow, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required %b", {coin, start, credit, credit_full, overflow, timeout}, 8'b0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_coin_accept();
    lock = 1'b1;
    coin_raw = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 6) begin
        n_checks++;
        if (credit !== 3'd0) begin n_fail++; $display("FAIL credit_before_e7: got %0d required 0", credit); end
      end
      if (e == 7) begin
        n_checks++;
        if (credit !== 3'd1) begin n_fail++; $display("FAIL credit_e7: got %0d required 1", credit); end
        n_checks++;
        if (coin !== 1'b0) begin n_fail++; $display("FAIL coin_e7: got %b required 0", coin); end
      end
      if (e == 8) begin
        n_checks++;
        if (coin !== 1'b1) begin n_fail++; $display("FAIL coin_e8: got %b required 1", coin); end
        n_checks++;
        if (credit !== 3'd0) begin n_fail++; $display("FAIL credit_e8: got %0d required 0", credit); end
      end
      if (e == 15) begin
        n_checks++;
        if (coin !== 1'b1) begin n_fail++; $display("FAIL coin_hold: got %b required 1", coin); end
      end
    end
    coin_raw = 1'b0;
    unlock   = 1'b1;
    tick();
    unlock = 1'b0;
    n_checks++;
    if (coin !== 1'b0) begin n_fail++; $display("FAIL coin_after_unlock: got %b required 0", coin); end
    repeat (8) tick();
    n_checks++;
    if ({credit, overflow, start} !== 5'b0) begin
      n_fail++;
      $display("FAIL coin_settle: got %b required %b", {credit, overflow, start}, 5'b0);
    end
  endtask

  task automatic test_glitch();
    coin_raw = 1'b1;
    repeat (3) tick();
    coin_raw = 1'b0;
    for (int e = 4; e <= 14; e++) begin
      tick();
      n_checks++;
      if ({credit, coin, overflow} !== 5'b0) begin
        n_fail++;
        $display("FAIL glitch_e%0d: got %b required %b", e, {credit, coin, overflow}, 5'b0);
      end
    end
  endtask

  task automatic test_start();
    lock = 1'b0;
    start_raw = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      tick();
      if (e == 9)  start_raw = 1'b0;
      if (e == 16) start_raw = 1'b1;
      if (e == 22) start_raw = 1'b0;
      if (e == 6) begin
        n_checks++;
        if (start !== 1'b0) begin n_fail++; $display("FAIL start_e6: got %b required 0", start); end
      end
      if (e >= 7) begin
        n_checks++;
        if (start !== 1'b1 || coin !== 1'b0) begin
          n_fail++;
          $display("FAIL start_hold_e%0d: got start=%b coin=%b required start=1 coin=0", e, start, coin);
        end
      end
    end
    lock = 1'b1;
    tick();
    n_checks++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL start_drop: got %b required 0", start); end
    for (int e = 0; e < 12; e++) begin
      tick();
      n_checks++;
      if (start !== 1'b0 || coin !== 1'b0) begin
        n_fail++;
        $display("FAIL start_no_extra: got start=%b coin=%b required 0 0", start, coin);
      end
    end
  endtask

  task automatic test_overflow();
    lock = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      coin_raw = 1'b1;
      for (int e = 1; e <= 16; e++) begin
        tick();
        if (e == 8) coin_raw = 1'b0;
        if (e == 7) begin
          n_checks++;
          if (credit !== ((k < 7) ? 3'(k) : 3'd7)) begin
            n_fail++;
            $display("FAIL credit_pulse%0d: got %0d required %0d", k, credit, (k < 7) ? k : 7);
          end
          n_checks++;
          if (overflow !== (k == 8)) begin
            n_fail++;
            $display("FAIL overflow_pulse%0d: got %b required %b", k, overflow, (k == 8));
          end
          n_checks++;
          if (credit_full !== (k >= 7)) begin
            n_fail++;
            $display("FAIL credit_full_pulse%0d: got %b required %b", k, credit_full, (k >= 7));
          end
        end
        if (e == 8 && k == 8) begin
          n_checks++;
          if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_width: got %b required 0", overflow); end
        end
      end
    end
    lock = 1'b1;
    tick();
    n_checks++;
    if (coin !== 1'b1 || credit !== 3'd6) begin
      n_fail++;
      $display("FAIL consume_after_full: got coin=%b credit=%0d required coin=1 credit=6", coin, credit);
    end
  endtask

  task automatic test_reset_midhandshake();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (coin !== 1'b0 || credit !== 3'd0 || credit_full !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got coin=%b credit=%0d full=%b required 0 0 0", coin, credit, credit_full);
    end
    for (int e = 0; e < 12; e++) begin
      tick();
      n_checks++;
      if (coin !== 1'b0 || start !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: got coin=%b start=%b required 0 0", coin, start);
      end
    end
  endtask

  task automatic test_timeout();
    lock = 1'b1;
    coin_raw = 1'b1;
    for (int e = 1; e <= 8; e++) tick();
    coin_raw = 1'b0;
    n_checks++;
    if (coin !== 1'b1) begin n_fail++; $display("FAIL tmo_coin: got %b required 1", coin); end
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
    lock   = 1'b0;
`ifdef SESSION_TIMEOUT_EN
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e <= 15) begin
        n_checks++;
        if (start !== 1'b0 || timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_early_e%0d: got start=%b timeout=%b required 0 0", e, start, timeout);
        end
      end
      if (e == 16) begin
        n_checks++;
        if (start !== 1'b1 || timeout !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_expire: got start=%b timeout=%b required 1 1", start, timeout);
        end
      end
      if (e == 17) begin
        n_checks++;
        if (start !== 1'b1 || timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_pulse_width: got start=%b timeout=%b required 1 0", start, timeout);
        end
      end
    end
`else
    for (int e = 1; e <= 100; e++) begin
      tick();
      n_checks++;
      if (start !== 1'b0 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL no_timeout_e%0d: got start=%b timeout=%b required 0 0", e, start, timeout);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_coin_accept();
    test_glitch();
    test_start();
    test_overflow();
    test_reset_midhandshake();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
